// File: rtl/error_logger.sv
// Turns the monitor's per-sample XOR difference word into test results: sample/error/bit
// counters, first-error capture and a small FIFO of recent failing samples for the host.
module error_logger #(
  parameter int WIDTH       = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            i_diff,
  input  logic                        i_en,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_clear,
  output logic                        o_busy,
  output logic                        o_halted,
  output logic [CNT_WIDTH-1:0]        o_sample_cnt,
  output logic [CNT_WIDTH-1:0]        o_err_cnt,
  output logic [CNT_WIDTH-1:0]        o_bit_cnt,
  output logic                        o_first_vld,
  output logic [CNT_WIDTH-1:0]        o_first_idx,
  output logic [WIDTH-1:0]            o_first_diff,
  output logic                        o_rd_valid,
  output logic [CNT_WIDTH+WIDTH-1:0]  o_rd_data,
  input  logic                        i_rd_ready,
  output logic                        o_overflow
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PCW = $clog2(WIDTH + 1);
  localparam int SW  = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_WIDTH{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_nxt;

  logic                 accept;
  logic [CNT_WIDTH-1:0] idx;
  logic                 s1_acc, s1_err;
  logic [WIDTH-1:0]     s1_diff;
  logic [CNT_WIDTH-1:0] s1_idx;
  logic [PCW-1:0]       pc;
  logic [SW-1:0]        bit_sum;
  logic [CNT_WIDTH-1:0] bit_nxt;

  logic [CNT_WIDTH+WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]                wr_ptr, rd_ptr;
  logic                       empty, full, pop, push_ok, drop;

  assign accept = (state == RUN) && i_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (i_start && !i_stop) state_nxt = RUN;
        RUN: begin
          if (i_stop)
            state_nxt = IDLE;
          else if ((STOP_ON_ERR != 0) && i_en && (i_diff != '0))
            state_nxt = HALTED;
        end
        HALTED:  state_nxt = HALTED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign o_busy   = (state == RUN);
  assign o_halted = (state == HALTED);

  // Stage 1: sample index and registered accept/diff/error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      s1_acc  <= 1'b0;
      s1_err  <= 1'b0;
      s1_diff <= '0;
      s1_idx  <= '0;
    end else if (i_clear) begin
      idx     <= '0;
      s1_acc  <= 1'b0;
      s1_err  <= 1'b0;
      s1_diff <= '0;
      s1_idx  <= '0;
    end else begin
      s1_acc <= accept;
      s1_err <= accept && (i_diff != '0);
      if (accept) begin
        s1_diff <= i_diff;
        s1_idx  <= idx;
        if (idx != '1) idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) pc = pc + PCW'(s1_diff[i]);
  end

  // Sum is one bit wider than either operand so the clamp sees the carry.
  assign bit_sum = SW'(o_bit_cnt) + SW'(pc);
  assign bit_nxt = (bit_sum > CNT_MAX) ? '1 : bit_sum[CNT_WIDTH-1:0];

  // Stage 2: counters and first-error capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_sample_cnt <= '0;
      o_err_cnt    <= '0;
      o_bit_cnt    <= '0;
      o_first_vld  <= 1'b0;
      o_first_idx  <= '0;
      o_first_diff <= '0;
    end else if (i_clear) begin
      o_sample_cnt <= '0;
      o_err_cnt    <= '0;
      o_bit_cnt    <= '0;
      o_first_vld  <= 1'b0;
      o_first_idx  <= '0;
      o_first_diff <= '0;
    end else begin
      if (s1_acc && o_sample_cnt != '1) o_sample_cnt <= o_sample_cnt + 1'b1;
      if (s1_err && o_err_cnt != '1)    o_err_cnt    <= o_err_cnt + 1'b1;
      if (s1_acc)                       o_bit_cnt    <= bit_nxt;
      if (s1_err && !o_first_vld) begin
        o_first_vld  <= 1'b1;
        o_first_idx  <= s1_idx;
        o_first_diff <= s1_diff;
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = i_rd_ready && !empty;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign push_ok = s1_err && (!full || pop);
  assign drop    = s1_err && full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (i_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= {s1_idx, s1_diff};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop)  rd_ptr     <= rd_ptr + 1'b1;
      if (drop) o_overflow <= 1'b1;
    end
  end

  assign o_rd_valid = !empty;
  assign o_rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
